match_window_counter: RTL and testbench
=======================================

# match_window_counter

Downstream consumer of the `1101` Mealy sequence detector. It samples the detector's one-cycle `o` pulse as `match` every clock and counts matches over fixed windows of `WIN_CYCLES` clocks. At the end of each window it presents the count on a valid/ready output register for the host/status logic.

## Interface
- `CNT_WIDTH`, default 8: width of the match accumulator and of `out_count`.
- `WIN_CYCLES`, default 16: clocks per window; legal range is 2 to 65535.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  run request; counting happens only while this is high.
- `clear`  in  1  synchronous flush of all state, including the output register.
- `match`  in  1  detector output `o`, sampled at each rising edge.
- `out_count`  out  CNT_WIDTH  match count of the most recent completed window.
- `out_valid`  out  1  `out_count` holds an unconsumed result.
- `out_ready`  in  1  consumer accepts the result on an edge where `out_valid` is also high.
- `overrun`  out  1  sticky flag: an unconsumed result was overwritten.

## Operation
- Internal state:
  - FSM with states IDLE and COUNT.
  - Window counter `win_cnt`, width $clog2(WIN_CYCLES).
  - Accumulator `acc`, CNT_WIDTH bits.
- IDLE:
  - `win_cnt` and `acc` are held at 0; `match` is ignored.
  - `enable`=1 at an edge moves the FSM to COUNT.
- COUNT, each edge with `enable`=1:
  - `acc` is loaded with `acc + match`.
  - `win_cnt` increments.
- Window end (COUNT, `enable`=1, `win_cnt`==WIN_CYCLES-1):
  - `out_count` is loaded with `acc + match`.
  - `out_valid` is set to 1.
  - `acc` and `win_cnt` are set to 0.
  - The FSM stays in COUNT, so the next window starts with no gap.
- `enable`=0 while in COUNT:
  - The FSM goes to IDLE and the partial window is discarded.
  - `match` on that edge is ignored.
  - `out_count`, `out_valid` and `overrun` are unchanged.
- Handshake:
  - A transfer occurs at an edge where `out_valid` and `out_ready` are both 1.
  - After a transfer, `out_valid` goes to 0 unless a window end happens on the same edge.
  - `out_count` holds its value after a transfer.
- Simultaneous events:
  - Window end and transfer on the same edge: the new result is loaded, `out_valid` stays 1, no overrun.
  - Window end while `out_valid`=1 with no transfer: `out_count` is overwritten with the newest result and `overrun` is set to 1.
  - `overrun` stays at 1 until `clear` or `rst`.
- `clear`=1:
  - Priority is above all other inputs except `rst`.
  - FSM goes to IDLE; `acc`, `win_cnt`, `out_count`, `out_valid` and `overrun` are all set to 0.
- Arithmetic: `acc` is unsigned and CNT_WIDTH bits wide. Overflow behaviour is set by the macro under Configuration.

## Timing
- Reset values: FSM in IDLE, `win_cnt`=0, `acc`=0, `out_count`=0, `out_valid`=0, `overrun`=0.
- Reset asserted mid-window or mid-handshake forces all of the above immediately, with no clock needed.
- Edge numbering: `enable` is high at edge E0, taking the FSM from IDLE to COUNT.
  - `match` is counted at edges E1 through E(WIN_CYCLES).
  - `out_valid` is first seen high after edge E(WIN_CYCLES).
- Window results after that arrive every WIN_CYCLES edges.
- All outputs are registered; there is no combinational path from any input to any output.
- `match` is sampled 1 for every edge on which it is high. The detector produces at most one high cycle per match, so overlapping input `1101101` yields 2 counts.

## Configuration
- `MWC_SATURATE_EN` defined: `acc` saturates at 2^CNT_WIDTH-1, and further matches in that window are dropped.
- `MWC_SATURATE_EN` undefined: `acc` wraps modulo 2^CNT_WIDTH.
- The macro has no effect when WIN_CYCLES <= 2^CNT_WIDTH-1.

## Test plan
- Reset and idle:
  - Stimulus: `rst` pulsed mid-window, then `enable`=0 with `match`=1 for 20 cycles.
  - Response: all outputs 0 immediately on `rst`; `out_valid` stays 0 throughout.
- Basic count (WIN_CYCLES=16, `out_ready`=1):
  - Stimulus: `enable` high at E0; `match` high at edges E3, E7 and E16.
  - Response: `out_valid`=1 with `out_count`=3 after E16; `out_valid`=0 after E17.
- Back-to-back windows:
  - Stimulus: `match` high on every odd edge; `out_ready`=1.
  - Response: each result is 8, arriving after E16, E32 and E48; `overrun`=0.
- Overrun:
  - Stimulus: `out_ready`=0; two windows with 2 matches then 5 matches.
  - Response: after E32, `out_count`=5, `out_valid`=1, `overrun`=1.
  - Then `out_ready`=1: `out_valid` drops and `overrun` stays 1.
- Abort and clear:
  - Stimulus: `enable` dropped at E10 with 4 matches counted; re-enabled at E12 with 1 match in the new window.
  - Response: that result is 1. A following `clear` pulse zeroes `out_count`, `out_valid` and `overrun`.
- Saturation (CNT_WIDTH=3, WIN_CYCLES=16):
  - Stimulus: `match` held at 1 for the whole window.
  - Response: `out_count`=7 with `MWC_SATURATE_EN` defined; `out_count`=0 without it.

Source files
------------

// File: rtl/match_window_counter.sv
// Counts 1101-detector match pulses over fixed WIN_CYCLES-clock windows and presents each count on a valid/ready register.
// Define MWC_SATURATE_EN to make the accumulator saturate instead of wrapping.
module match_window_counter #(
    parameter int CNT_WIDTH  = 8,
    parameter int WIN_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 match,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overrun
);

    localparam int WIN_W = $clog2(WIN_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t               state;
    logic [WIN_W-1:0]     win_cnt;
    logic [CNT_WIDTH-1:0] acc;

    logic [CNT_WIDTH-1:0] acc_next;
    logic                 win_end;
    logic                 xfer;

    function automatic logic [CNT_WIDTH-1:0] acc_add(
        input logic [CNT_WIDTH-1:0] a,
        input logic                 m
    );
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {{CNT_WIDTH{1'b0}}, m};
`ifdef MWC_SATURATE_EN
        if (sum[CNT_WIDTH]) begin
            sum[CNT_WIDTH-1:0] = '1;
        end
`endif
        return sum[CNT_WIDTH-1:0];
    endfunction

    always_comb begin
        acc_next = acc_add(acc, match);
        win_end  = (state == COUNT) && enable && (win_cnt == WIN_LAST);
        xfer     = out_valid && out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            win_cnt   <= '0;
            acc       <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            win_cnt   <= '0;
            acc       <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                win_cnt <= '0;
                acc     <= '0;
                if (enable) begin
                    state <= COUNT;
                end
            end else begin
                // Dropping enable discards the partial window; the output register is untouched.
                if (!enable) begin
                    state   <= IDLE;
                    win_cnt <= '0;
                    acc     <= '0;
                end else if (win_end) begin
                    win_cnt <= '0;
                    acc     <= '0;
                end else begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    acc     <= acc_next;
                end
            end

            // A window end always wins the output register; an unread result being replaced flags overrun.
            if (win_end) begin
                out_count <= acc_next;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_match_window_counter.sv
// Directed bench for match_window_counter: default instance for the main behaviour,
// a CNT_WIDTH=3 instance for the overflow/saturation case.
module tb_match_window_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       clear;
    logic       match;
    logic       out_ready;
    logic [7:0] out_count;
    logic       out_valid;
    logic       overrun;

    logic       s_enable;
    logic       s_match;
    logic       s_ready;
    logic [2:0] s_count;
    logic       s_valid;
    logic       s_overrun;

    int tests = 0;
    int fails = 0;

`ifdef MWC_SATURATE_EN
    localparam int SAT_EXP = 7;
`else
    localparam int SAT_EXP = 0;
`endif

    always #5 clk = ~clk;

    match_window_counter #(.CNT_WIDTH(8), .WIN_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clear     (clear),
        .match     (match),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    match_window_counter #(.CNT_WIDTH(3), .WIN_CYCLES(16)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .enable    (s_enable),
        .clear     (clear),
        .match     (s_match),
        .out_count (s_count),
        .out_valid (s_valid),
        .out_ready (s_ready),
        .overrun   (s_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        clear     = 1'b0;
        match     = 1'b0;
        out_ready = 1'b1;
        s_enable  = 1'b0;
        s_match   = 1'b0;
        s_ready   = 1'b1;
        tick();
        check("rst_count", out_count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_sat_valid", s_valid, 0);
        rst = 1'b0;

        // Fill one window with an unread result, run into the next window, then reset asynchronously.
        out_ready = 1'b0;
        enable    = 1'b1;
        match     = 1'b1;
        for (int e = 0; e <= 16; e++) tick();
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_count", out_count, 16);
        for (int e = 17; e <= 19; e++) tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", out_count, 0);
        check("async_rst_valid", out_valid, 0);
        check("async_rst_overrun", overrun, 0);
        #1;
        rst = 1'b0;

        // Idle with match high: nothing may be counted.
        enable    = 1'b0;
        match     = 1'b1;
        out_ready = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            check("idle_valid", out_valid, 0);
        end
        check("idle_count", out_count, 0);

        // Basic count: matches at E3, E7, E16.
        enable = 1'b1;
        match  = 1'b0;
        tick();
        for (int e = 1; e <= 16; e++) begin
            match = (e == 3 || e == 7 || e == 16);
            tick();
            if (e == 15) check("basic_valid_e15", out_valid, 0);
        end
        check("basic_valid", out_valid, 1);
        check("basic_count", out_count, 3);
        match = 1'b0;
        tick();
        check("basic_valid_e17", out_valid, 0);
        check("basic_count_hold", out_count, 3);

        // Back-to-back windows with match on every odd edge.
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        for (int e = 1; e <= 48; e++) begin
            match = (e % 2 == 1);
            tick();
            if (e % 16 == 0) begin
                check("b2b_valid", out_valid, 1);
                check("b2b_count", out_count, 8);
            end else if (e % 16 == 1 && e > 1) begin
                check("b2b_drop", out_valid, 0);
            end
        end
        check("b2b_overrun", overrun, 0);

        // Overrun: 2 matches then 5 matches with nobody reading.
        enable = 1'b0;
        match  = 1'b0;
        tick();
        out_ready = 1'b0;
        enable    = 1'b1;
        tick();
        for (int e = 1; e <= 32; e++) begin
            match = (e == 2 || e == 5 || e == 18 || e == 20 || e == 22 || e == 24 || e == 26);
            tick();
            if (e == 16) begin
                check("ovr_w1_valid", out_valid, 1);
                check("ovr_w1_count", out_count, 2);
                check("ovr_w1_overrun", overrun, 0);
            end
        end
        check("ovr_w2_count", out_count, 5);
        check("ovr_w2_valid", out_valid, 1);
        check("ovr_w2_overrun", overrun, 1);
        out_ready = 1'b1;
        match     = 1'b0;
        tick();
        check("ovr_read_valid", out_valid, 0);
        check("ovr_read_overrun", overrun, 1);
        check("ovr_read_count", out_count, 5);
        enable = 1'b0;
        tick();
        check("ovr_sticky", overrun, 1);

        // Abort at E10 after 4 matches, restart at E12, one match in the new window.
        enable = 1'b1;
        match  = 1'b0;
        tick();
        for (int e = 1; e <= 11; e++) begin
            enable = !(e == 10 || e == 11);
            match  = (e % 2 == 0);
            tick();
        end
        enable = 1'b1;
        match  = 1'b1;
        tick();
        for (int e = 13; e <= 28; e++) begin
            match = (e == 20);
            tick();
            if (e == 27) check("abort_no_early", out_valid, 0);
        end
        check("abort_valid", out_valid, 1);
        check("abort_count", out_count, 1);
        check("abort_overrun", overrun, 1);
        clear  = 1'b1;
        enable = 1'b0;
        match  = 1'b0;
        tick();
        clear = 1'b0;
        check("clear_count", out_count, 0);
        check("clear_valid", out_valid, 0);
        check("clear_overrun", overrun, 0);

        // Overflow: 16 matches into a 3-bit accumulator.
        s_enable = 1'b1;
        s_match  = 1'b1;
        tick();
        for (int e = 1; e <= 16; e++) tick();
        check("sat_valid", s_valid, 1);
        check("sat_count", s_count, SAT_EXP);
        check("sat_overrun", s_overrun, 0);
        s_enable = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
